// File: rtl/pc_seq_if.sv
// Control-unit <-> program-counter bundle: control strobes and jump target in,
// instruction address and status out.
interface pc_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PHASES = 4
);
  localparam int unsigned PhW = $clog2(PHASES);

  logic              enable;
  logic              finish;
  logic              load;
  logic              inc;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] C_bus;
  logic [ADDR_W-1:0] ins_address;
  logic [PhW-1:0]    phase;
  logic              commit;
  logic              running;
  logic              halted;
  logic              stack_err;

  // Control unit side
  modport master (
    output enable, finish, load, inc, call, ret, C_bus,
    input  ins_address, phase, commit, running, halted, stack_err
  );

  // Program counter side
  modport slave (
    input  enable, finish, load, inc, call, ret, C_bus,
    output ins_address, phase, commit, running, halted, stack_err
  );
endinterface

// File: rtl/pc_seq.sv
// Multi-phase program counter with return-address stack and IDLE/RUN/HALT control.
// Control inputs only take effect on the last phase of each instruction (commit).
module pc_seq #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       PHASES      = 4,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  pc_bus
);

  localparam int unsigned PhW = $clog2(PHASES);
  // sp counts 0..STACK_DEPTH inclusive, hence the +1
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);
  localparam logic [PhW-1:0] PhLast = PhW'(PHASES - 1);
  localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              commit_w;
  logic              stack_empty;
  logic              stack_full;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] top_entry;

  assign commit_w    = (state_q == StRun) && (phase_q == PhLast);
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SpFull);

  // State register and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= '0;
      addr_q  <= RESET_ADDR;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; entries survive reset, only sp is cleared
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SpW'(i) == sp_q) stack_q[i] <= push_addr;
      end
    end
  end

  // Top-of-stack read (entry sp-1); compare-select avoids index width trouble
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SpW'(i) == sp_q - SpW'(1)) top_entry = stack_q[i];
    end
  end

  // Next-state: errors and finish at commit both park the FSM in HALT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pc_bus.enable) state_d = StRun;
      StRun: begin
        if (commit_w) begin
          if (pc_bus.finish) begin
            state_d = StHalt;
          end else if (pc_bus.ret) begin
            if (stack_empty) state_d = StHalt;
          end else if (pc_bus.call) begin
            if (stack_full) state_d = StHalt;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: phase counter and prioritised commit action
  always_comb begin
    phase_d   = phase_q;
    addr_d    = addr_q;
    sp_d      = sp_q;
    err_d     = err_q;
    push      = 1'b0;
    push_addr = addr_q + ADDR_W'(1);
    if (state_q == StRun) begin
      phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
      if (commit_w && !pc_bus.finish) begin
        if (pc_bus.ret) begin
          if (stack_empty) begin
            err_d = 1'b1;
          end else begin
            addr_d = top_entry;
            sp_d   = sp_q - SpW'(1);
          end
        end else if (pc_bus.call) begin
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push   = 1'b1;
            sp_d   = sp_q + SpW'(1);
            addr_d = pc_bus.C_bus;
          end
        end else if (pc_bus.load) begin
          addr_d = pc_bus.C_bus;
        end else if (pc_bus.inc) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    pc_bus.ins_address = addr_q;
    pc_bus.phase       = phase_q;
    pc_bus.commit      = commit_w;
    pc_bus.running     = (state_q == StRun);
    pc_bus.halted      = (state_q == StHalt);
    pc_bus.stack_err   = err_q;
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: one instance at 8-bit/4-phase/depth-2 and one at
// 12-bit/3-phase with a non-zero reset address.
module tb_pc_seq;

  logic clk;
  logic reset0;
  logic reset1;

  int n_checks = 0;
  int n_fail   = 0;

  pc_seq_if #(.ADDR_W(8),  .PHASES(4)) bus0 ();
  pc_seq_if #(.ADDR_W(12), .PHASES(3)) bus1 ();

  pc_seq #(
    .ADDR_W(8), .PHASES(4), .STACK_DEPTH(2), .RESET_ADDR(8'h00)
  ) dut0 (
    .clk    (clk),
    .reset  (reset0),
    .pc_bus (bus0)
  );

  pc_seq #(
    .ADDR_W(12), .PHASES(3), .STACK_DEPTH(2), .RESET_ADDR(12'h123)
  ) dut1 (
    .clk    (clk),
    .reset  (reset1),
    .pc_bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic en, input logic fin, input logic ld, input logic in,
                      input logic cl, input logic rt, input logic [7:0] cb);
    bus0.enable = en;
    bus0.finish = fin;
    bus0.load   = ld;
    bus0.inc    = in;
    bus0.call   = cl;
    bus0.ret    = rt;
    bus0.C_bus  = cb;
  endtask

  // One full instruction on dut0 starting at phase 0: every control asserted on
  // the non-commit phases (must be ignored), the real controls on the commit phase.
  task automatic instr0(input logic fin, input logic ld, input logic in, input logic cl,
                        input logic rt, input logic [7:0] cb, input logic [7:0] cur);
    for (int p = 0; p < 3; p++) begin
      set0(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
      check_eq("nc_phase", 32'(bus0.phase), 32'(p));
      check_eq("nc_addr", 32'(bus0.ins_address), 32'(cur));
      tick();
    end
    set0(1'b0, fin, ld, in, cl, rt, cb);
    check_eq("commit_hi", 32'(bus0.commit), 32'd1);
    tick();
    set0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic restart0();
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    set0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    set0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    set0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus1.enable = 1'b0; bus1.finish = 1'b0; bus1.load = 1'b0;
    bus1.inc = 1'b0; bus1.call = 1'b0; bus1.ret = 1'b0; bus1.C_bus = '0;
    tick();

    // Reset state
    check_eq("rst_addr", 32'(bus0.ins_address), 32'h00);
    check_eq("rst_phase", 32'(bus0.phase), 32'd0);
    check_eq("rst_run", 32'(bus0.running), 32'd0);
    check_eq("rst_halt", 32'(bus0.halted), 32'd0);
    check_eq("rst_err", 32'(bus0.stack_err), 32'd0);
    check_eq("rst_commit", 32'(bus0.commit), 32'd0);

    // IDLE ignores controls
    reset0 = 1'b0;
    set0(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    tick();
    check_eq("idle_addr", 32'(bus0.ins_address), 32'h00);
    check_eq("idle_run", 32'(bus0.running), 32'd0);

    // Enable pulse with inc held: address steps only after each commit
    set0(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus0.enable = 1'b0;
    check_eq("run_on", 32'(bus0.running), 32'd1);
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        check_eq("step_phase", 32'(bus0.phase), 32'(p));
        check_eq("step_addr", 32'(bus0.ins_address), 32'(k));
        check_eq("step_commit", 32'(bus0.commit), (p == 3) ? 32'd1 : 32'd0);
        tick();
      end
    end
    bus0.inc = 1'b0;
    check_eq("step_end", 32'(bus0.ins_address), 32'h04);

    // Wrap, call/ret
    instr0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h04);
    check_eq("load_ff", 32'(bus0.ins_address), 32'hFF);
    instr0(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    check_eq("wrap_addr", 32'(bus0.ins_address), 32'h00);
    check_eq("wrap_err", 32'(bus0.stack_err), 32'd0);
    instr0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    instr0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h10);
    check_eq("call_tgt", 32'(bus0.ins_address), 32'h40);
    instr0(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40);
    instr0(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h41);
    check_eq("ret_addr", 32'(bus0.ins_address), 32'h11);

    // Overflow on third nested call (depth 2; sp back to 0 after the ret)
    instr0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h11);
    instr0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 8'h50);
    check_eq("call2", 32'(bus0.ins_address), 32'h60);
    check_eq("call2_err", 32'(bus0.stack_err), 32'd0);
    instr0(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 8'h60);
    check_eq("ovf_err", 32'(bus0.stack_err), 32'd1);
    check_eq("ovf_halt", 32'(bus0.halted), 32'd1);
    check_eq("ovf_addr", 32'(bus0.ins_address), 32'h60);
    set0(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    for (int i = 0; i < 5; i++) tick();
    check_eq("halt_addr", 32'(bus0.ins_address), 32'h60);
    check_eq("halt_phase", 32'(bus0.phase), 32'd0);
    check_eq("halt_stay", 32'(bus0.halted), 32'd1);
    check_eq("halt_run", 32'(bus0.running), 32'd0);
    set0(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Underflow: ret with empty stack
    restart0();
    check_eq("rst2_err", 32'(bus0.stack_err), 32'd0);
    check_eq("rst2_halt", 32'(bus0.halted), 32'd0);
    instr0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00);
    instr0(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33);
    check_eq("unf_err", 32'(bus0.stack_err), 32'd1);
    check_eq("unf_halt", 32'(bus0.halted), 32'd1);
    check_eq("unf_addr", 32'(bus0.ins_address), 32'h33);

    // finish beats load and inc
    restart0();
    instr0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 8'h00);
    check_eq("fin_halt", 32'(bus0.halted), 32'd1);
    check_eq("fin_addr", 32'(bus0.ins_address), 32'h00);
    check_eq("fin_err", 32'(bus0.stack_err), 32'd0);

    // Reset mid-instruction
    restart0();
    instr0(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00);
    tick();
    tick();
    check_eq("mid_phase", 32'(bus0.phase), 32'd2);
    reset0 = 1'b1;
    tick();
    check_eq("mid_addr", 32'(bus0.ins_address), 32'h00);
    check_eq("mid_ph0", 32'(bus0.phase), 32'd0);
    check_eq("mid_run", 32'(bus0.running), 32'd0);
    check_eq("mid_err", 32'(bus0.stack_err), 32'd0);

    // Second configuration: 12-bit, 3 phases, reset address 0x123
    check_eq("d1_rst_addr", 32'(bus1.ins_address), 32'h123);
    check_eq("d1_rst_phase", 32'(bus1.phase), 32'd0);
    reset1 = 1'b0;
    bus1.enable = 1'b1;
    bus1.inc = 1'b1;
    tick();
    bus1.enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 3; p++) begin
        check_eq("d1_phase", 32'(bus1.phase), 32'(p));
        check_eq("d1_addr", 32'(bus1.ins_address), 32'h123 + 32'(k));
        check_eq("d1_commit", 32'(bus1.commit), (p == 2) ? 32'd1 : 32'd0);
        tick();
      end
    end
    bus1.inc = 1'b0;
    bus1.load = 1'b1;
    bus1.C_bus = 12'hFFF;
    for (int i = 0; i < 3; i++) tick();
    check_eq("d1_load", 32'(bus1.ins_address), 32'hFFF);
    bus1.load = 1'b0;
    bus1.inc = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("d1_wrap", 32'(bus1.ins_address), 32'h000);
    check_eq("d1_err", 32'(bus1.stack_err), 32'd0);
    tick();
    check_eq("d1_mid_ph", 32'(bus1.phase), 32'd1);
    reset1 = 1'b1;
    tick();
    check_eq("d1_mid_addr", 32'(bus1.ins_address), 32'h123);
    check_eq("d1_mid_ph0", 32'(bus1.phase), 32'd0);
    check_eq("d1_mid_run", 32'(bus1.running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
